// File: rtl/resp_signature_capture.sv
// resp_signature_capture: compacts NUM_SAMPLES handshaked response vectors
// into a single W-bit MISR signature for cross-simulator comparison.
// Optional golden compare is enabled by defining
// RESP_SIGNATURE_CAPTURE_GOLDEN_CMP_EN (adds golden/pass/fail ports).
module resp_signature_capture #(
   parameter int unsigned  W           = 96,
   parameter int unsigned  NUM_SAMPLES = 16,
   parameter logic [W-1:0] SEED        = '0,
   parameter logic [W-1:0] POLY        = W'(96'h641)
) (
   input  logic                                 clkin_data,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [W-1:0]                         in_data,
   output logic [$clog2(NUM_SAMPLES+1)-1:0]     sample_cnt,
   output logic [W-1:0]                         signature,
   output logic                                 done
`ifdef RESP_SIGNATURE_CAPTURE_GOLDEN_CMP_EN
   ,
   input  logic [W-1:0]                         golden,
   output logic                                 pass,
   output logic                                 fail
`endif
);

   localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [W-1:0]  sig_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          xfer;
   logic          last_xfer;
   logic [W-1:0]  misr_step;

`ifdef RESP_SIGNATURE_CAPTURE_GOLDEN_CMP_EN
   logic          pass_nxt;
   logic          fail_nxt;
`endif

   // Handshake and status decode straight from the state register
   assign in_ready  = (state == S_RUN);
   assign done      = (state == S_DONE);
   assign xfer      = in_valid && in_ready;
   assign last_xfer = xfer && (sample_cnt == CW'(NUM_SAMPLES - 1));

   // One MISR shift with feedback on the outgoing MSB, then fold in the vector
   assign misr_step = {signature[W-2:0], 1'b0}
                    ^ (signature[W-1] ? POLY : '0)
                    ^ in_data;

   // Next-state and next-data logic
   always_comb begin
      state_nxt = state;
      sig_nxt   = signature;
      cnt_nxt   = sample_cnt;
`ifdef RESP_SIGNATURE_CAPTURE_GOLDEN_CMP_EN
      pass_nxt  = pass;
      fail_nxt  = fail;
`endif
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = S_RUN;
               sig_nxt   = SEED;
               cnt_nxt   = '0;
`ifdef RESP_SIGNATURE_CAPTURE_GOLDEN_CMP_EN
               pass_nxt  = 1'b0;
               fail_nxt  = 1'b0;
`endif
            end
         end
         S_RUN: begin
            if (xfer) begin
               sig_nxt = misr_step;
               cnt_nxt = CW'(sample_cnt + CW'(1));
            end
            if (last_xfer) begin
               state_nxt = S_DONE;
`ifdef RESP_SIGNATURE_CAPTURE_GOLDEN_CMP_EN
               pass_nxt  = (misr_step == golden);
               fail_nxt  = (misr_step != golden);
`endif
            end
         end
         default: begin
            state_nxt = S_IDLE;
            sig_nxt   = SEED;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clkin_data) begin
      if (rst) begin
         state      <= S_IDLE;
         signature  <= SEED;
         sample_cnt <= '0;
`ifdef RESP_SIGNATURE_CAPTURE_GOLDEN_CMP_EN
         pass       <= 1'b0;
         fail       <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         signature  <= sig_nxt;
         sample_cnt <= cnt_nxt;
`ifdef RESP_SIGNATURE_CAPTURE_GOLDEN_CMP_EN
         pass       <= pass_nxt;
         fail       <= fail_nxt;
`endif
      end
   end

endmodule
